// File: rtl/ddr_model_fifo_sync.sv
// Single-clock read-return FIFO for the DDR3 app-interface behavioural model.
// Registered dout (no fall-through), registered status flags and one-cycle overflow/underflow strobes.
module ddr_model_fifo_sync #(
    parameter int pDATA_WIDTH       = 64,
    parameter int pDEPTH            = 32,
    parameter int pPROG_FULL_THRESH = 16
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [pDATA_WIDTH-1:0] din,
    input  logic                   wr_en,
    input  logic                   rd_en,
    output logic [pDATA_WIDTH-1:0] dout,
    output logic                   full,
    output logic                   empty,
    output logic                   prog_full,
    output logic                   overflow,
    output logic                   underflow
);

    localparam int AW = $clog2(pDEPTH);
    localparam int CW = AW + 1;

    logic [pDATA_WIDTH-1:0] mem_r [pDEPTH];
    logic [AW-1:0]          wr_ptr_r;
    logic [AW-1:0]          rd_ptr_r;
    logic [CW-1:0]          count_r;
    logic [CW-1:0]          count_nxt_s;
    logic                   wr_acc_s;
    logic                   rd_acc_s;

    // Acceptance uses the registered flags, i.e. the state before this edge.
    assign wr_acc_s = wr_en & ~full;
    assign rd_acc_s = rd_en & ~empty;

    // Next occupancy from accepted operations.
    always_comb begin
        count_nxt_s = count_r;
        if (wr_acc_s && !rd_acc_s) begin
            count_nxt_s = count_r + CW'(1);
        end else if (!wr_acc_s && rd_acc_s) begin
            count_nxt_s = count_r - CW'(1);
        end else begin
            count_nxt_s = count_r;
        end
    end

    // Storage array; writes are suppressed while reset is asserted.
    always_ff @(posedge clk) begin
        if (!rst && wr_acc_s) begin
            mem_r[wr_ptr_r] <= din;
        end
    end

    // Pointers, occupancy, registered read data, flags and strobes.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_r  <= {AW{1'b0}};
            rd_ptr_r  <= {AW{1'b0}};
            count_r   <= {CW{1'b0}};
            dout      <= {pDATA_WIDTH{1'b0}};
            full      <= 1'b0;
            empty     <= 1'b1;
            prog_full <= 1'b0;
            overflow  <= 1'b0;
            underflow <= 1'b0;
        end else begin
            if (wr_acc_s) begin
                wr_ptr_r <= wr_ptr_r + AW'(1);
            end
            if (rd_acc_s) begin
                rd_ptr_r <= rd_ptr_r + AW'(1);
                dout     <= mem_r[rd_ptr_r];
            end
            count_r   <= count_nxt_s;
            full      <= (count_nxt_s == CW'(pDEPTH));
            empty     <= (count_nxt_s == {CW{1'b0}});
            prog_full <= (count_nxt_s >= CW'(pPROG_FULL_THRESH));
            overflow  <= wr_en & full;
            underflow <= rd_en & empty;
        end
    end

endmodule

// File: tb/tb_ddr_model_fifo_sync.sv
// Directed bench for ddr_model_fifo_sync: a vector table for single-word and empty-read
// cases, then hand-written sequences for thresholds, full/overflow, wrap and mid-run reset.
module tb_ddr_model_fifo_sync;

    logic        clk;
    logic        rst;
    logic [63:0] din;
    logic        wr_en;
    logic        rd_en;
    logic [63:0] dout;
    logic        full;
    logic        empty;
    logic        prog_full;
    logic        overflow;
    logic        underflow;

    int total;
    int bad;

    ddr_model_fifo_sync #(
        .pDATA_WIDTH      (64),
        .pDEPTH           (32),
        .pPROG_FULL_THRESH(16)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .din      (din),
        .wr_en    (wr_en),
        .rd_en    (rd_en),
        .dout     (dout),
        .full     (full),
        .empty    (empty),
        .prog_full(prog_full),
        .overflow (overflow),
        .underflow(underflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        rst;
        logic        wr;
        logic        rd;
        logic [63:0] din;
        logic [63:0] dout;
        logic        full;
        logic        empty;
        logic        pf;
        logic        ov;
        logic        un;
    } vec_t;

    vec_t vecs [10];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total = total + 1;
        if (act !== exp) begin
            bad = bad + 1;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Drive inputs, take one rising edge, then settle 1 time unit before sampling.
    task automatic step(input logic r, input logic w, input logic rd, input logic [63:0] d);
        rst   = r;
        wr_en = w;
        rd_en = rd;
        din   = d;
        @(posedge clk);
        #1;
    endtask

    task automatic idle_step();
        step(1'b0, 1'b0, 1'b0, 64'h0);
    endtask

    logic [63:0] q [$];
    logic [63:0] exp_dout;
    int          wr_cnt;
    int          cyc;
    logic        do_rd;

    initial begin
        total = 0;
        bad   = 0;
        rst   = 1'b1;
        wr_en = 1'b0;
        rd_en = 1'b0;
        din   = 64'h0;

        //            rst   wr    rd    din                    dout                   full  empty pf    ov    un
        vecs[0] = '{1'b1, 1'b0, 1'b0, 64'h0,                 64'h0,                 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
        vecs[1] = '{1'b0, 1'b1, 1'b0, 64'h0123456789ABCDEF,  64'h0,                 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
        vecs[2] = '{1'b0, 1'b0, 1'b1, 64'h0,                 64'h0123456789ABCDEF,  1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
        vecs[3] = '{1'b0, 1'b0, 1'b0, 64'h0,                 64'h0123456789ABCDEF,  1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
        vecs[4] = '{1'b0, 1'b0, 1'b0, 64'h0,                 64'h0123456789ABCDEF,  1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
        vecs[5] = '{1'b0, 1'b0, 1'b1, 64'h0,                 64'h0123456789ABCDEF,  1'b0, 1'b1, 1'b0, 1'b0, 1'b1};
        vecs[6] = '{1'b0, 1'b0, 1'b0, 64'h0,                 64'h0123456789ABCDEF,  1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
        vecs[7] = '{1'b0, 1'b1, 1'b1, 64'hAAAA5555AAAA5555,  64'h0123456789ABCDEF,  1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
        vecs[8] = '{1'b0, 1'b0, 1'b1, 64'h0,                 64'hAAAA5555AAAA5555,  1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
        vecs[9] = '{1'b0, 1'b0, 1'b0, 64'h0,                 64'hAAAA5555AAAA5555,  1'b0, 1'b1, 1'b0, 1'b0, 1'b0};

        for (int i = 0; i < 10; i++) begin
            step(vecs[i].rst, vecs[i].wr, vecs[i].rd, vecs[i].din);
            chk($sformatf("v%0d_dout", i),  dout,             vecs[i].dout);
            chk($sformatf("v%0d_full", i),  {63'h0, full},      {63'h0, vecs[i].full});
            chk($sformatf("v%0d_empty", i), {63'h0, empty},     {63'h0, vecs[i].empty});
            chk($sformatf("v%0d_pf", i),    {63'h0, prog_full}, {63'h0, vecs[i].pf});
            chk($sformatf("v%0d_ov", i),    {63'h0, overflow},  {63'h0, vecs[i].ov});
            chk($sformatf("v%0d_un", i),    {63'h0, underflow}, {63'h0, vecs[i].un});
        end

        // prog_full threshold at 16 entries
        step(1'b1, 1'b0, 1'b0, 64'h0);
        for (int i = 0; i < 16; i++) begin
            step(1'b0, 1'b1, 1'b0, 64'(i));
            if (i == 14) chk("pf_after15", {63'h0, prog_full}, 64'h0);
            if (i == 15) chk("pf_after16", {63'h0, prog_full}, 64'h1);
        end
        chk("pf16_full", {63'h0, full}, 64'h0);
        step(1'b0, 1'b0, 1'b1, 64'h0);
        chk("pf_after_read", {63'h0, prog_full}, 64'h0);
        chk("pf_read_dout", dout, 64'h0);

        // fill to 32, rejected 33rd write, drain in order
        step(1'b1, 1'b0, 1'b0, 64'h0);
        for (int i = 0; i < 32; i++) begin
            step(1'b0, 1'b1, 1'b0, 64'(i));
            if (i == 30) chk("full_at31", {63'h0, full}, 64'h0);
        end
        chk("full_at32", {63'h0, full}, 64'h1);
        chk("full_pf", {63'h0, prog_full}, 64'h1);
        chk("full_ov_before", {63'h0, overflow}, 64'h0);
        step(1'b0, 1'b1, 1'b0, 64'hDEAD);
        chk("ov_strobe", {63'h0, overflow}, 64'h1);
        chk("ov_full_kept", {63'h0, full}, 64'h1);
        idle_step();
        chk("ov_one_cycle", {63'h0, overflow}, 64'h0);
        chk("ov_full_kept2", {63'h0, full}, 64'h1);
        for (int i = 0; i < 32; i++) begin
            step(1'b0, 1'b0, 1'b1, 64'h0);
            chk($sformatf("drain%0d", i), dout, 64'(i));
            if (i == 0) chk("full_drop", {63'h0, full}, 64'h0);
        end
        chk("drain_empty", {63'h0, empty}, 64'h1);
        chk("drain_no_un", {63'h0, underflow}, 64'h0);

        // simultaneous read+write while full: read accepted, write rejected
        step(1'b1, 1'b0, 1'b0, 64'h0);
        for (int i = 0; i < 32; i++) step(1'b0, 1'b1, 1'b0, 64'h500 + 64'(i));
        step(1'b0, 1'b1, 1'b1, 64'hBAD);
        chk("rwfull_ov", {63'h0, overflow}, 64'h1);
        chk("rwfull_dout", dout, 64'h500);
        chk("rwfull_full", {63'h0, full}, 64'h0);

        // interleaved traffic across several pointer wraps
        step(1'b1, 1'b0, 1'b0, 64'h0);
        q.delete();
        exp_dout = 64'h0;
        wr_cnt = 0;
        cyc = 0;
        while (wr_cnt < 100 || q.size() > 0) begin
            do_rd = (q.size() > 0) && (cyc[0] || q.size() >= 16 || wr_cnt >= 100);
            if (wr_cnt < 100) begin
                step(1'b0, 1'b1, do_rd, 64'h1000 + 64'(wr_cnt));
            end else begin
                step(1'b0, 1'b0, do_rd, 64'h0);
            end
            if (do_rd) exp_dout = q.pop_front();
            if (wr_cnt < 100) begin
                q.push_back(64'h1000 + 64'(wr_cnt));
                wr_cnt = wr_cnt + 1;
            end
            chk($sformatf("il%0d_dout", cyc), dout, exp_dout);
            chk($sformatf("il%0d_ovun", cyc), {62'h0, overflow, underflow}, 64'h0);
            cyc = cyc + 1;
        end
        chk("il_last", exp_dout, 64'h1000 + 64'd99);
        chk("il_empty", {63'h0, empty}, 64'h1);

        // reset with 10 entries stored and a nonzero dout
        for (int i = 0; i < 10; i++) step(1'b0, 1'b1, 1'b0, 64'h7700 + 64'(i));
        step(1'b0, 1'b0, 1'b1, 64'h0);
        step(1'b0, 1'b1, 1'b0, 64'h7799);
        chk("rst_pre_dout", dout, 64'h7700);
        step(1'b1, 1'b1, 1'b1, 64'h5151);
        chk("rst_empty", {63'h0, empty}, 64'h1);
        chk("rst_pf", {63'h0, prog_full}, 64'h0);
        chk("rst_dout", dout, 64'h0);
        idle_step();
        chk("rst_wr_ignored", {63'h0, empty}, 64'h1);
        step(1'b0, 1'b1, 1'b0, 64'hBEEF);
        chk("post_rst_nonempty", {63'h0, empty}, 64'h0);
        step(1'b0, 1'b0, 1'b1, 64'h0);
        chk("post_rst_dout", dout, 64'hBEEF);
        chk("post_rst_empty", {63'h0, empty}, 64'h1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
